// File: rtl/latch_bank_writer.sv
// Write initiator for a bank of level-sensitive D latches: setup / strobe / hold sequencing around a one-hot enable.
// Optional macro READBACK_CHECK_EN adds a Q readback compare (lat_q in, rb_err out).
module latch_bank_writer #(
    parameter int W       = 8,
    parameter int N       = 4,
    parameter int AW      = 2,
    parameter int T_SETUP = 1,
    parameter int T_PULSE = 2,
    parameter int T_HOLD  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [W-1:0]  in_data,
    output logic [W-1:0]  lat_d,
    output logic [N-1:0]  lat_en,
    output logic          busy,
    output logic          done,
    output logic          addr_err
`ifdef READBACK_CHECK_EN
    ,
    input  logic [N*W-1:0] lat_q,
    output logic           rb_err
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]    r_state;
    logic [7:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [N-1:0]  w_onehot;
    logic          w_addr_ok;
    logic          w_cnt_last;

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign w_cnt_last = (r_cnt == 8'd1);

    // Decoding by equality means an out-of-range address yields an all-zero enable.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (32'(r_addr) == i) w_onehot[i] = 1'b1;
        end
    end
    assign w_addr_ok = |w_onehot;

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) r_addr <= in_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            lat_d    <= '0;
            lat_en   <= '0;
            done     <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            addr_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_SETUP;
                        r_cnt   <= 8'(T_SETUP);
                        lat_d   <= in_data;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_last) begin
                        r_state <= S_STROBE;
                        r_cnt   <= 8'(T_PULSE);
                        lat_en  <= w_onehot;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_STROBE: begin
                    if (w_cnt_last) begin
                        r_state <= S_HOLD;
                        r_cnt   <= 8'(T_HOLD);
                        lat_en  <= '0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_last) begin
                        r_state  <= S_IDLE;
                        done     <= 1'b1;
                        addr_err <= ~w_addr_ok;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef READBACK_CHECK_EN
    logic [W-1:0] w_q_sel;

    always_comb begin
        w_q_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (32'(r_addr) == i) w_q_sel = lat_q[i*W +: W];
        end
    end

    // lat_d is frozen from accept through HOLD, so it serves as the registered write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_err <= 1'b0;
        end else begin
            rb_err <= (r_state == S_HOLD) && w_cnt_last && w_addr_ok && (w_q_sel != lat_d);
        end
    end
`else
    // Without readback there is nothing further to compare.
`endif

endmodule

// File: tb/tb_latch_bank_writer.sv
// Directed bench for latch_bank_writer driving four behavioural D latches.
module tb_latch_bank_writer;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [W-1:0]  in_data;
    logic [W-1:0]  lat_d;
    logic [N-1:0]  lat_en;
    logic          busy;
    logic          done;
    logic          addr_err;
    logic          lat_clr;
    logic [W-1:0]  q [N];

    int total = 0;
    int bad   = 0;

`ifdef READBACK_CHECK_EN
    logic [N*W-1:0] lat_q;
    logic           rb_err;
    logic           rb_force;

    always_comb begin
        lat_q = '0;
        for (int i = 0; i < N; i++) lat_q[i*W +: W] = q[i];
        if (rb_force) lat_q[W] = 1'b0;
    end
`endif

    latch_bank_writer #(.W(W), .N(N), .AW(AW), .T_SETUP(1), .T_PULSE(2), .T_HOLD(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .lat_d    (lat_d),
        .lat_en   (lat_en),
        .busy     (busy),
        .done     (done),
        .addr_err (addr_err)
`ifdef READBACK_CHECK_EN
        ,
        .lat_q    (lat_q),
        .rb_err   (rb_err)
`endif
    );

    // Behavioural latch bank: transparent while its enable is high.
    always @(*) begin
        for (int i = 0; i < N; i++) begin
            if (lat_clr) q[i] = '0;
            else if (lat_en[i]) q[i] = lat_d;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a request for one edge; returns in cycle 1 of the transaction.
    task automatic write_start(input logic [AW-1:0] a, input logic [W-1:0] d);
        in_addr  = a;
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        lat_clr  = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
`ifdef READBACK_CHECK_EN
        rb_force = 1'b0;
`endif
        #12;
        chk("rst_ready",  32'(in_ready), 32'd1);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_en",     32'(lat_en),   32'd0);
        chk("rst_d",      32'(lat_d),    32'd0);
        chk("rst_done",   32'(done),     32'd0);
        chk("rst_aerr",   32'(addr_err), 32'd0);
        lat_clr = 1'b0;
        rst_n   = 1'b1;
        step();

        // single write addr 2 / A5
        write_start(3'd2, 8'hA5);
        chk("w1_d_c1",     32'(lat_d),    32'hA5);
        chk("w1_en_c1",    32'(lat_en),   32'h0);
        chk("w1_busy_c1",  32'(busy),     32'd1);
        chk("w1_ready_c1", 32'(in_ready), 32'd0);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("w1_en",   32'(lat_en), (c == 2 || c == 3) ? 32'b0100 : 32'b0);
            chk("w1_done", 32'(done),   (c == 5) ? 32'd1 : 32'd0);
        end
        chk("w1_aerr", 32'(addr_err), 32'd0);
        chk("w1_q2",   32'(q[2]), 32'hA5);
        chk("w1_q0",   32'(q[0]), 32'h00);
        chk("w1_q1",   32'(q[1]), 32'h00);
        chk("w1_q3",   32'(q[3]), 32'h00);

        // back-to-back with in_valid held
        in_addr  = 3'd1;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();
        in_addr = 3'd3;
        in_data = 8'hC3;
        chk("b2b_d_c1", 32'(lat_d), 32'h3C);
        for (int c = 2; c <= 10; c++) begin
            step();
            if (c == 5) begin
                chk("b2b_ready_c5", 32'(in_ready), 32'd1);
                chk("b2b_d_c5",     32'(lat_d),    32'h3C);
            end
            if (c == 6) begin
                chk("b2b_d_c6", 32'(lat_d), 32'hC3);
                in_valid = 1'b0;
            end
            chk("b2b_en", 32'(lat_en),
                (c == 2 || c == 3) ? 32'b0010 : (c == 7 || c == 8) ? 32'b1000 : 32'b0);
            chk("b2b_done", 32'(done), (c == 5 || c == 10) ? 32'd1 : 32'd0);
        end
        chk("b2b_q1", 32'(q[1]), 32'h3C);
        chk("b2b_q3", 32'(q[3]), 32'hC3);
        chk("b2b_q2", 32'(q[2]), 32'hA5);

        // out-of-range address
        write_start(3'd5, 8'h5A);
        chk("oor_en_c1", 32'(lat_en), 32'h0);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("oor_en",   32'(lat_en),   32'h0);
            chk("oor_done", 32'(done),     (c == 5) ? 32'd1 : 32'd0);
            chk("oor_aerr", 32'(addr_err), (c == 5) ? 32'd1 : 32'd0);
        end
        chk("oor_q0", 32'(q[0]), 32'h00);
        chk("oor_q2", 32'(q[2]), 32'hA5);

        // reset during STROBE
        write_start(3'd3, 8'h77);
        step();
        chk("rs_en_pre", 32'(lat_en), 32'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_en",    32'(lat_en),   32'h0);
        chk("rs_d",     32'(lat_d),    32'h0);
        chk("rs_done",  32'(done),     32'd0);
        chk("rs_busy",  32'(busy),     32'd0);
        chk("rs_ready", 32'(in_ready), 32'd1);
        step();
        chk("rs_done_hold", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rs_done_post", 32'(done), 32'd0);
        chk("rs_busy_post", 32'(busy), 32'd0);
        write_start(3'd0, 8'h11);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("rs_w_en",   32'(lat_en), (c == 2 || c == 3) ? 32'b0001 : 32'b0);
            chk("rs_w_done", 32'(done),   (c == 5) ? 32'd1 : 32'd0);
        end
        chk("rs_w_q0", 32'(q[0]), 32'h11);

`ifdef READBACK_CHECK_EN
        write_start(3'd2, 8'h0F);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("rb_ok_done", 32'(done),   (c == 5) ? 32'd1 : 32'd0);
            chk("rb_ok_err",  32'(rb_err), 32'd0);
        end
        rb_force = 1'b1;
        write_start(3'd1, 8'hFF);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("rb_bad_done", 32'(done),   (c == 5) ? 32'd1 : 32'd0);
            chk("rb_bad_err",  32'(rb_err), (c == 5) ? 32'd1 : 32'd0);
        end
        rb_force = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
